pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf.sv | 107 ++++++++++
 tb/tb_pipe_stage_buf.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage buffer: a small circular FIFO between two pipeline stages,
// with flush (redirect kill), bubble accounting and flushed-entry accounting.
module pipe_stage_buf #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [CNT_W-1:0]             bubble_cnt,
    output logic [CNT_W-1:0]             flush_cnt
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [OCC_W-1:0] FULL    = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_W:0]    flush_sum;
    logic              push;
    logic              pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Handshake: a beat moves on a rising edge where valid and ready are both high.
    // in_ready may depend combinationally on out_ready (a full buffer accepts while
    // its head leaves); out_valid/out_data come only from flops. flush cancels both
    // transfers in its cycle.
    assign out_valid  = (count_q != '0);
    assign in_ready   = (count_q != FULL) | out_ready;
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign push       = in_valid & in_ready & ~flush;
    assign pop        = out_valid & out_ready & ~flush;
    assign count      = count_q;
    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;

    always_comb begin
        mem_d        = mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        flush_sum    = {1'b0, flush_cnt_q} + (CNT_W+1)'(count_q);

        if (!out_valid && bubble_cnt_q != CNT_MAX) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end

        if (flush) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            flush_cnt_d = flush_sum[CNT_W] ? CNT_MAX : flush_sum[CNT_W-1:0];
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            count_d = count_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // Payload storage is not reset; out_data masking hides stale entries.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf across DEPTH=1/2/3 and a narrow-counter variant
// sharing one input stimulus set; each scenario begins from reset.
module tb_pipe_stage_buf;

    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_ready;

    logic          d2_in_ready, d2_out_valid;
    logic [DW-1:0] d2_out_data;
    logic [1:0]    d2_count;
    logic [15:0]   d2_bubble_cnt, d2_flush_cnt;

    logic          d3_in_ready, d3_out_valid;
    logic [DW-1:0] d3_out_data;
    logic [1:0]    d3_count;
    logic [15:0]   d3_bubble_cnt, d3_flush_cnt;

    logic          d1_in_ready, d1_out_valid;
    logic [DW-1:0] d1_out_data;
    logic [0:0]    d1_count;
    logic [15:0]   d1_bubble_cnt, d1_flush_cnt;

    logic          ds_in_ready, ds_out_valid;
    logic [DW-1:0] ds_out_data;
    logic [1:0]    ds_count;
    logic [3:0]    ds_bubble_cnt, ds_flush_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];

    pipe_stage_buf #(.DATA_W(DW), .DEPTH(2), .CNT_W(16)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready), .in_data(in_data),
        .flush(flush), .out_valid(d2_out_valid), .out_ready(out_ready), .out_data(d2_out_data),
        .count(d2_count), .bubble_cnt(d2_bubble_cnt), .flush_cnt(d2_flush_cnt));

    pipe_stage_buf #(.DATA_W(DW), .DEPTH(3), .CNT_W(16)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d3_in_ready), .in_data(in_data),
        .flush(flush), .out_valid(d3_out_valid), .out_ready(out_ready), .out_data(d3_out_data),
        .count(d3_count), .bubble_cnt(d3_bubble_cnt), .flush_cnt(d3_flush_cnt));

    pipe_stage_buf #(.DATA_W(DW), .DEPTH(1), .CNT_W(16)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d1_in_ready), .in_data(in_data),
        .flush(flush), .out_valid(d1_out_valid), .out_ready(out_ready), .out_data(d1_out_data),
        .count(d1_count), .bubble_cnt(d1_bubble_cnt), .flush_cnt(d1_flush_cnt));

    pipe_stage_buf #(.DATA_W(DW), .DEPTH(2), .CNT_W(4)) u_ds (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ds_in_ready), .in_data(in_data),
        .flush(flush), .out_valid(ds_out_valid), .out_ready(out_ready), .out_data(ds_out_data),
        .count(ds_count), .bubble_cnt(ds_bubble_cnt), .flush_cnt(ds_flush_cnt));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] next_val;
        logic          exp_rdy;

        // reset state
        do_reset();
        @(negedge clk);
        check("rst_out_valid", d2_out_valid, 0);
        check("rst_out_data", d2_out_data, 0);
        check("rst_in_ready", d2_in_ready, 1);
        check("rst_count", d2_count, 0);
        check("rst_bubble", d2_bubble_cnt, 0);
        check("rst_flush_cnt", d2_flush_cnt, 0);

        // streaming, DEPTH=2
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_data = DW'(i);
            @(negedge clk);
            check("stream_in_ready", d2_in_ready, 1);
            if (i == 1) begin
                check("stream_first_valid", d2_out_valid, 0);
            end else begin
                check("stream_data", d2_out_data, i - 1);
                check("stream_count", d2_count, 1);
            end
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_last", d2_out_data, 10);
        check("stream_bubble", d2_bubble_cnt, 1);
        step();
        @(negedge clk);
        check("stream_empty", d2_count, 0);

        // back-pressure and full-with-pop, DEPTH=2
        do_reset();
        in_valid = 1'b1;
        in_data  = 16'h00aa;
        @(negedge clk);
        check("bp_ready_a", d2_in_ready, 1);
        step();
        in_data = 16'h00bb;
        @(negedge clk);
        check("bp_ready_b", d2_in_ready, 1);
        check("bp_head_a", d2_out_data, 16'h00aa);
        step();
        in_data = 16'h00cc;
        @(negedge clk);
        check("bp_full_count", d2_count, 2);
        check("bp_ready_c", d2_in_ready, 0);
        step();
        check("bp_hold_count", d2_count, 2);
        out_ready = 1'b1;
        @(negedge clk);
        check("fwp_in_ready", d2_in_ready, 1);
        check("fwp_head", d2_out_data, 16'h00aa);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("fwp_count", d2_count, 2);
        check("fwp_head_adv", d2_out_data, 16'h00bb);
        step();
        @(negedge clk);
        check("bp_out_c", d2_out_data, 16'h00cc);
        check("bp_count_1", d2_count, 1);
        step();
        @(negedge clk);
        check("bp_drained_valid", d2_out_valid, 0);
        check("bp_drained_data", d2_out_data, 0);

        // flush, DEPTH=3
        do_reset();
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = DW'(i * 17);
            step();
        end
        flush     = 1'b1;
        in_data   = 16'h0044;
        out_ready = 1'b1;
        @(negedge clk);
        check("fl_pre_count", d3_count, 3);
        check("fl_pre_head", d3_out_data, 17);
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("fl_count", d3_count, 0);
        check("fl_out_valid", d3_out_valid, 0);
        check("fl_out_data", d3_out_data, 0);
        check("fl_flush_cnt", d3_flush_cnt, 3);
        step();
        check("fl_dropped", d3_count, 0);
        in_valid = 1'b1;
        in_data  = 16'h0055;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("fl_after_data", d3_out_data, 16'h0055);
        check("fl_after_count", d3_count, 1);

        // wrap-around with random handshakes, DEPTH=3
        do_reset();
        exp_q.delete();
        next_val = 16'h0100;
        for (int i = 0; i < 24; i++) begin
            if (i < 20) begin
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            in_data = next_val;
            @(negedge clk);
            exp_rdy = (exp_q.size() != 3) || out_ready;
            check("wrap_ready", d3_in_ready, exp_rdy);
            check("wrap_count", d3_count, exp_q.size());
            if (exp_q.size() != 0) begin
                check("wrap_data", d3_out_data, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end else begin
                check("wrap_valid", d3_out_valid, 0);
            end
            if (in_valid && exp_rdy) begin
                exp_q.push_back(in_data);
                next_val = next_val + 1'b1;
            end
            step();
        end

        // DEPTH=1 behaves as a pipeline register
        do_reset();
        in_valid = 1'b1;
        in_data  = 16'h0077;
        step();
        @(negedge clk);
        check("d1_ready_full", d1_in_ready, 0);
        check("d1_data", d1_out_data, 16'h0077);
        step();
        out_ready = 1'b1;
        in_data   = 16'h0078;
        @(negedge clk);
        check("d1_ready_pop", d1_in_ready, 1);
        check("d1_data_held", d1_out_data, 16'h0077);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("d1_data_next", d1_out_data, 16'h0078);
        check("d1_count", d1_count, 1);

        // counter saturation and mid-stream reset, CNT_W=4
        do_reset();
        for (int i = 0; i < 10; i++) step();
        @(negedge clk);
        check("sat_bubble_10", ds_bubble_cnt, 10);
        for (int i = 0; i < 10; i++) step();
        @(negedge clk);
        check("sat_bubble_15", ds_bubble_cnt, 15);
        in_valid = 1'b1;
        in_data  = 16'h0001;
        step();
        in_data = 16'h0002;
        step();
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        check("sat_flush_cnt", ds_flush_cnt, 2);
        check("sat_flush_count", ds_count, 0);
        in_valid = 1'b1;
        in_data  = 16'h0003;
        step();
        @(negedge clk);
        check("mid_count", ds_count, 1);
        rst = 1'b1;
        step();
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_count", ds_count, 0);
        check("mid_rst_bubble", ds_bubble_cnt, 0);
        check("mid_rst_flush", ds_flush_cnt, 0);
        check("mid_rst_valid", ds_out_valid, 0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
